// File: rtl/commit_store_buffer.sv
// In-order buffer of committed stores: drains to data memory over req/ack and
// serves store-to-load forwarding lookups against all not-yet-acknowledged entries.
module commit_store_buffer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enq_valid,
    output logic                  enq_ready,
    input  logic [ADDR_WIDTH-1:0] enq_addr,
    input  logic [DATA_WIDTH-1:0] enq_data,
    input  logic [2:0]            enq_funct3,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [3:0]            mem_wr_strb,
    input  logic                  mem_wr_ack,
    input  logic                  ld_query_valid,
    input  logic [ADDR_WIDTH-1:0] ld_query_addr,
    input  logic [2:0]            ld_query_funct3,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  fwd_stall,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  empty
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam int unsigned WW = ADDR_WIDTH - 2;

    typedef struct packed {
        logic [WW-1:0]         waddr;
        logic [DATA_WIDTH-1:0] data;
        logic [3:0]            strb;
    } entry_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    entry_t entries [DEPTH];
    entry_t enq_entry;
    entry_t head_entry;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          full;
    logic          push;
    logic          pop;

    state_t                state;
    state_t                state_n;
    logic                  req_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [3:0]            strb_n;

    logic                  unused_funct3;

    assign unused_funct3 = ld_query_funct3[2];

    // Occupancy from the wrap-bit pointers
    assign full      = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);
    assign empty     = (head == tail);
    assign count     = CNT_WIDTH'(tail - head);
    assign enq_ready = !full;
    assign push      = enq_valid && !full;
    assign head_entry = entries[head[IW-1:0]];

    // Lane placement and data replication done once, at enqueue
    always_comb begin
        enq_entry.waddr = enq_addr[ADDR_WIDTH-1:2];
        enq_entry.data  = enq_data;
        enq_entry.strb  = 4'b0000;
        case (enq_funct3)
            3'b000: begin
                enq_entry.strb = 4'b0001 << enq_addr[1:0];
                enq_entry.data = {4{enq_data[7:0]}};
            end
            3'b001: begin
                enq_entry.strb = 4'b0011 << {enq_addr[1], 1'b0};
                enq_entry.data = {2{enq_data[15:0]}};
            end
            3'b010: begin
                enq_entry.strb = 4'hF;
            end
            default: begin
                enq_entry.strb = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail[IW-1:0]] <= enq_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
        end
    end

    // Drain FSM: next state and next registered write-port values
    always_comb begin
        state_n = state;
        req_n   = mem_wr_req;
        addr_n  = mem_wr_addr;
        data_n  = mem_wr_data;
        strb_n  = mem_wr_strb;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    req_n   = 1'b1;
                    addr_n  = {head_entry.waddr, 2'b00};
                    data_n  = head_entry.data;
                    strb_n  = head_entry.strb;
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_wr_ack) begin
                    pop     = 1'b1;
                    req_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mem_wr_req  <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_strb <= '0;
        end else begin
            state       <= state_n;
            mem_wr_req  <= req_n;
            mem_wr_addr <= addr_n;
            mem_wr_data <= data_n;
            mem_wr_strb <= strb_n;
        end
    end

    // Forwarding: scan oldest to youngest so the youngest overlap wins
    logic [3:0]            ld_mask;
    logic                  sel_found;
    logic [3:0]            sel_strb;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [IW-1:0]         scan_idx;
    logic                  covers;

    always_comb begin
        ld_mask = 4'b0000;
        case (ld_query_funct3[1:0])
            2'b00:   ld_mask = 4'b0001 << ld_query_addr[1:0];
            2'b01:   ld_mask = 4'b0011 << {ld_query_addr[1], 1'b0};
            2'b10:   ld_mask = 4'hF;
            default: ld_mask = 4'b0000;
        endcase
    end

    always_comb begin
        sel_found = 1'b0;
        sel_strb  = 4'b0000;
        sel_data  = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            scan_idx = head[IW-1:0] + IW'(k);
            if ((CNT_WIDTH'(k) < count) &&
                (entries[scan_idx].waddr == ld_query_addr[ADDR_WIDTH-1:2]) &&
                ((entries[scan_idx].strb & ld_mask) != 4'b0000)) begin
                sel_found = 1'b1;
                sel_strb  = entries[scan_idx].strb;
                sel_data  = entries[scan_idx].data;
            end
        end
    end

    assign covers    = ((sel_strb & ld_mask) == ld_mask);
    assign fwd_hit   = ld_query_valid && sel_found && covers;
    assign fwd_stall = ld_query_valid && sel_found && !covers;
    assign fwd_data  = fwd_hit ? sel_data : '0;

endmodule

// File: tb/tb_commit_store_buffer.sv
// Self-checking bench for commit_store_buffer: directed vectors, corner sequences,
// and a randomized run against a queue-based reference model.
module tb_commit_store_buffer;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enq_valid;
    logic          enq_ready;
    logic [AW-1:0] enq_addr;
    logic [DW-1:0] enq_data;
    logic [2:0]    enq_funct3;
    logic          mem_wr_req;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic [3:0]    mem_wr_strb;
    logic          mem_wr_ack;
    logic          ld_query_valid;
    logic [AW-1:0] ld_query_addr;
    logic [2:0]    ld_query_funct3;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          fwd_stall;
    logic [CW-1:0] count;
    logic          empty;

    commit_store_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_addr(enq_addr),
        .enq_data(enq_data), .enq_funct3(enq_funct3),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_strb(mem_wr_strb), .mem_wr_ack(mem_wr_ack),
        .ld_query_valid(ld_query_valid), .ld_query_addr(ld_query_addr),
        .ld_query_funct3(ld_query_funct3),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [AW-1:0] waddr;
        logic [3:0]    strb;
        logic [DW-1:0] data;
    } st_t;

    typedef struct {
        logic [2:0]    f3;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic [3:0]    exp_strb;
    } vec_t;

    st_t  model_q[$];
    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [AW-1:0] a);
        case (f3)
            3'b000:  return 4'(1 << a[1:0]);
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            3'b010:  return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [DW-1:0] st_data(input logic [2:0] f3, input logic [DW-1:0] d);
        case (f3)
            3'b000:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'b001:  return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] ld_mask(input logic [2:0] f3, input logic [AW-1:0] a);
        case (f3[1:0])
            2'b00:   return 4'(1 << a[1:0]);
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    task automatic enq(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] f3);
        enq_valid = 1'b1; enq_addr = a; enq_data = d; enq_funct3 = f3;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        for (int i = 0; i < 20 && !mem_wr_req; i++) tick();
        if (!mem_wr_req) chk({name, "_req_timeout"}, 64'(mem_wr_req), 64'd1);
    endtask

    task automatic ack_one();
        mem_wr_ack = 1'b1;
        tick();
        mem_wr_ack = 1'b0;
    endtask

    task automatic query(input logic [AW-1:0] a, input logic [2:0] f3);
        ld_query_valid = 1'b1; ld_query_addr = a; ld_query_funct3 = f3;
        #1;
    endtask

    initial begin
        logic [AW-1:0] exp_a;
        int            req_seen;
        int            starve;

        vecs[0] = '{3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF};
        vecs[1] = '{3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0000_1000, 32'hABAB_ABAB, 4'h8};
        vecs[2] = '{3'b000, 32'h0000_2001, 32'h1234_56C7, 32'h0000_2000, 32'hC7C7_C7C7, 4'h2};
        vecs[3] = '{3'b001, 32'h0000_2002, 32'h0000_1234, 32'h0000_2000, 32'h1234_1234, 4'hC};
        vecs[4] = '{3'b001, 32'h0000_3001, 32'hABCD_5678, 32'h0000_3000, 32'h5678_5678, 4'h3};
        vecs[5] = '{3'b011, 32'h0000_4002, 32'h0000_0099, 32'h0000_4000, 32'h0000_0000, 4'h0};
        vecs[6] = '{3'b010, 32'h0000_5004, 32'hCAFE_F00D, 32'h0000_5004, 32'hCAFE_F00D, 4'hF};

        rst_n = 1'b0; enq_valid = 1'b0; enq_addr = '0; enq_data = '0; enq_funct3 = '0;
        mem_wr_ack = 1'b0; ld_query_valid = 1'b0; ld_query_addr = '0; ld_query_funct3 = '0;
        tick(); tick();
        chk("rst_req", 64'(mem_wr_req), 64'd0);
        chk("rst_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_strb", 64'(mem_wr_strb), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_ready", 64'(enq_ready), 64'd1);
        #2 rst_n = 1'b1;
        tick();

        // Latency: enqueue at edge N, req visible after edge N+1, ack on 2nd req cycle
        enq(32'h0000_1000, 32'hDEAD_BEEF, 3'b010);
        chk("lat_count1", 64'(count), 64'd1);
        chk("lat_req_early", 64'(mem_wr_req), 64'd0);
        tick();
        chk("lat_req", 64'(mem_wr_req), 64'd1);
        chk("lat_addr", 64'(mem_wr_addr), 64'h1000);
        chk("lat_data", 64'(mem_wr_data), 64'hDEAD_BEEF);
        chk("lat_strb", 64'(mem_wr_strb), 64'hF);
        tick();
        chk("lat_req_hold", 64'(mem_wr_req), 64'd1);
        ack_one();
        chk("lat_req_drop", 64'(mem_wr_req), 64'd0);
        chk("lat_count0", 64'(count), 64'd0);

        // Table of single-store encodings
        for (int v = 0; v < 7; v++) begin
            enq(vecs[v].addr, vecs[v].data, vecs[v].f3);
            wait_req("vec");
            chk($sformatf("vec%0d_addr", v), 64'(mem_wr_addr), 64'(vecs[v].exp_addr));
            chk($sformatf("vec%0d_strb", v), 64'(mem_wr_strb), 64'(vecs[v].exp_strb));
            if (vecs[v].exp_strb != 4'h0)
                chk($sformatf("vec%0d_data", v), 64'(mem_wr_data), 64'(vecs[v].exp_data));
            ack_one();
            chk($sformatf("vec%0d_count", v), 64'(count), 64'd0);
        end

        // Two stores in order with one idle cycle between writes
        enq(32'h0000_1003, 32'h0000_00AB, 3'b000);
        enq(32'h0000_2002, 32'h0000_1234, 3'b001);
        wait_req("seq");
        chk("seq1_addr", 64'(mem_wr_addr), 64'h1000);
        chk("seq1_strb", 64'(mem_wr_strb), 64'h8);
        chk("seq1_data", 64'(mem_wr_data), 64'hABAB_ABAB);
        ack_one();
        chk("seq_idle", 64'(mem_wr_req), 64'd0);
        tick();
        chk("seq2_req", 64'(mem_wr_req), 64'd1);
        chk("seq2_addr", 64'(mem_wr_addr), 64'h2000);
        chk("seq2_strb", 64'(mem_wr_strb), 64'hC);
        chk("seq2_data", 64'(mem_wr_data), 64'h1234_1234);
        ack_one();
        tick();

        // Fill to full, drop an enqueue, free one slot, wrap the tail
        for (int i = 0; i < 8; i++) enq(32'h0000_4000 + 32'(4 * i), 32'(i), 3'b010);
        chk("full_count", 64'(count), 64'd8);
        chk("full_ready", 64'(enq_ready), 64'd0);
        enq(32'h0000_6000, 32'h66, 3'b010);
        chk("full_drop_count", 64'(count), 64'd8);
        wait_req("full");
        chk("full_head_addr", 64'(mem_wr_addr), 64'h4000);
        ack_one();
        chk("full_ready_after", 64'(enq_ready), 64'd1);
        chk("full_count_after", 64'(count), 64'd7);
        enq(32'h0000_5000, 32'h55, 3'b010);
        chk("wrap_count", 64'(count), 64'd8);
        for (int i = 1; i <= 8; i++) begin
            exp_a = (i == 8) ? 32'h0000_5000 : 32'h0000_4000 + 32'(4 * i);
            wait_req("drain");
            chk($sformatf("drain%0d_addr", i), 64'(mem_wr_addr), 64'(exp_a));
            ack_one();
        end
        chk("drain_empty", 64'(empty), 64'd1);

        // Forwarding: youngest overlap decides hit vs stall
        enq(32'h0000_3000, 32'h1122_3344, 3'b010);
        enq(32'h0000_3001, 32'h0000_0055, 3'b000);
        query(32'h0000_3001, 3'b100);
        chk("fwd_lbu_hit", 64'(fwd_hit), 64'd1);
        chk("fwd_lbu_data", 64'(fwd_data), 64'h5555_5555);
        chk("fwd_lbu_stall", 64'(fwd_stall), 64'd0);
        query(32'h0000_3000, 3'b010);
        chk("fwd_lw_stall", 64'(fwd_stall), 64'd1);
        chk("fwd_lw_hit", 64'(fwd_hit), 64'd0);
        chk("fwd_lw_data", 64'(fwd_data), 64'd0);
        query(32'h0000_3002, 3'b001);
        chk("fwd_lh_old_hit", 64'(fwd_hit), 64'd1);
        chk("fwd_lh_old_data", 64'(fwd_data), 64'h1122_3344);
        query(32'h0000_3004, 3'b000);
        chk("fwd_miss", 64'({fwd_hit, fwd_stall}), 64'd0);
        query(32'h0000_3001, 3'b100);
        ld_query_valid = 1'b0;
        #1;
        chk("fwd_gated", 64'({fwd_hit, fwd_stall, fwd_data}), 64'd0);
        for (int i = 0; i < 2; i++) begin
            wait_req("fwd_drain");
            ack_one();
        end
        tick();

        // Asynchronous reset in the middle of a write
        enq(32'h0000_7000, 32'h1, 3'b010);
        enq(32'h0000_7004, 32'h2, 3'b010);
        enq(32'h0000_7008, 32'h3, 3'b010);
        wait_req("rst_mid");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 64'(mem_wr_req), 64'd0);
        chk("rst_mid_count", 64'(count), 64'd0);
        chk("rst_mid_empty", 64'(empty), 64'd1);
        tick();
        #2 rst_n = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_wr_req) req_seen++;
        end
        chk("rst_mid_no_writes", 64'(req_seen), 64'd0);
        chk("rst_mid_ready", 64'(enq_ready), 64'd1);

        // Randomized run against the queue model
        model_q.delete();
        starve = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int  enq_pct;
            int  ack_pct;
            bool_t: begin end
            enq_pct = (cyc / 500 == 1) ? 85 : (cyc / 500 == 2) ? 20 : 55;
            ack_pct = (cyc / 500 == 1) ? 25 : (cyc / 500 == 2) ? 90 : 50;
            enq_valid       = ($urandom_range(0, 99) < enq_pct);
            enq_addr        = 32'h0000_0100 | 32'($urandom_range(0, 15));
            enq_data        = $urandom;
            enq_funct3      = 3'($urandom_range(0, 3));
            mem_wr_ack      = ($urandom_range(0, 99) < ack_pct);
            ld_query_valid  = ($urandom_range(0, 3) != 0);
            ld_query_addr   = 32'h0000_0100 | 32'($urandom_range(0, 19));
            ld_query_funct3 = 3'($urandom_range(0, 7));
            #2;
            begin
                logic [3:0]    m;
                logic          found;
                logic [3:0]    s;
                logic [DW-1:0] d;
                logic          e_hit;
                logic          e_stall;
                chk("rnd_count", 64'(count), 64'(model_q.size()));
                chk("rnd_ready", 64'(enq_ready), 64'(model_q.size() < DEPTH));
                chk("rnd_empty", 64'(empty), 64'(model_q.size() == 0));
                if (mem_wr_req) begin
                    if (model_q.size() == 0) begin
                        chk("rnd_req_when_empty", 64'(mem_wr_req), 64'd0);
                    end else begin
                        chk("rnd_wr_addr", 64'(mem_wr_addr), 64'(model_q[0].waddr));
                        chk("rnd_wr_strb", 64'(mem_wr_strb), 64'(model_q[0].strb));
                        if (model_q[0].strb != 4'h0)
                            chk("rnd_wr_data", 64'(mem_wr_data), 64'(model_q[0].data));
                    end
                end
                starve = (model_q.size() != 0 && !mem_wr_req) ? starve + 1 : 0;
                if (starve > 3) begin
                    chk("rnd_drain_stuck", 64'(starve), 64'd0);
                    starve = 0;
                end
                m = ld_mask(ld_query_funct3, ld_query_addr);
                found = 1'b0; s = 4'h0; d = '0;
                for (int i = model_q.size() - 1; i >= 0 && !found; i--) begin
                    if (model_q[i].waddr[AW-1:2] == ld_query_addr[AW-1:2] &&
                        (model_q[i].strb & m) != 4'h0) begin
                        found = 1'b1; s = model_q[i].strb; d = model_q[i].data;
                    end
                end
                e_hit   = ld_query_valid && found && ((s & m) == m);
                e_stall = ld_query_valid && found && ((s & m) != m);
                chk("rnd_fwd_hit", 64'(fwd_hit), 64'(e_hit));
                chk("rnd_fwd_stall", 64'(fwd_stall), 64'(e_stall));
                chk("rnd_fwd_data", 64'(fwd_data), e_hit ? 64'(d) : 64'd0);
            end
            begin
                bit do_push;
                st_t n;
                do_push = enq_valid && (model_q.size() < DEPTH);
                if (mem_wr_req && mem_wr_ack && model_q.size() != 0) void'(model_q.pop_front());
                if (do_push) begin
                    n.waddr = {enq_addr[AW-1:2], 2'b00};
                    n.strb  = st_strb(enq_funct3, enq_addr);
                    n.data  = st_data(enq_funct3, enq_data);
                    model_q.push_back(n);
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/commit_store_buffer.md
Name: commit_store_buffer

Overview:
- FIFO of committed stores between the ROB commit stage and the data memory write port.
- The ROB pushes one architecturally committed store per cycle. The buffer drains stores in order to memory over a req/ack handshake.
- It also answers combinational store-to-load forwarding lookups from the load unit, covering every entry not yet acknowledged by memory.
- Committed entries are never flushed by mispredicts.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, store data width (fixed 32; 4 byte lanes)
DEPTH, 8, number of entries (power of two, >=2)
CNT_WIDTH, $clog2(DEPTH)+1, occupancy counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
enq_valid  input  1  commit stage presents a store
enq_ready  output  1  buffer can accept (count < DEPTH)
enq_addr  input  ADDR_WIDTH  store byte address
enq_data  input  DATA_WIDTH  rs2 value (low bits significant)
enq_funct3  input  3  000=SB, 001=SH, 010=SW
mem_wr_req  output  1  write request to data memory
mem_wr_addr  output  ADDR_WIDTH  word-aligned address (bits[1:0]=0)
mem_wr_data  output  DATA_WIDTH  lane-replicated write data
mem_wr_strb  output  4  byte enables
mem_wr_ack  input  1  memory accepted the write this cycle
ld_query_valid  input  1  load lookup valid
ld_query_addr  input  ADDR_WIDTH  load byte address
ld_query_funct3  input  3  load funct3 (size in bits[1:0])
fwd_hit  output  1  youngest overlapping store fully covers the load bytes
fwd_data  output  DATA_WIDTH  that store's aligned word data (mem_wr_data format)
fwd_stall  output  1  youngest overlapping store covers only part of the load bytes
count  output  CNT_WIDTH  occupancy
empty  output  1  count == 0

Behaviour:
- Storage: circular array with head/tail pointers of $clog2(DEPTH)+1 bits; the extra bit is the wrap bit.
  - Empty when pointers are equal.
  - Full when indices are equal and wrap bits differ.
  - count = tail - head.
- Enqueue: on an edge where enq_valid && enq_ready, store addr, data, funct3 at tail and increment tail.
  - At enqueue, precompute the entry's strobe and aligned data:
    - SB: strb = 4'b0001 << addr[1:0]; data = {4{data[7:0]}}.
    - SH: strb = 4'b0011 << {addr[1],1'b0}; data = {2{data[15:0]}}; addr[0] is ignored (misalignment trapped upstream).
    - SW: strb = 4'hF; data = data.
    - Other funct3: strb = 0; the entry still drains as a no-op write.
- enq_ready = !full. There is no bypass: when full, a same-cycle pop does not raise enq_ready.
- Drain FSM, states IDLE and WRITE:
  - IDLE: if !empty, register head fields into mem_wr_addr/data/strb, set mem_wr_req=1, go to WRITE.
  - WRITE: hold req, addr, data and strb stable until mem_wr_ack.
    - On ack: increment head (pop), clear mem_wr_req, return to IDLE.
    - Consequence: one idle cycle between consecutive writes.
  - mem_wr_ack outside WRITE is ignored.
- Latency: a store enqueued at edge N (buffer empty) gives mem_wr_req=1 in the cycle after edge N+1. A simultaneous enqueue and pop changes count by 0.
- Forwarding (combinational, ld_query_valid gated; all outputs 0 when it is low):
  - Load mask: LB/LBU = 1 << a[1:0]; LH/LHU = 3 << {a[1],0}; LW = 4'hF.
  - Overlap means entry.addr[ADDR_WIDTH-1:2] == query[ADDR_WIDTH-1:2] and (entry.strb & load_mask) != 0.
  - Select the youngest overlapping valid entry, searching from tail-1 back to head. This includes the entry currently in WRITE.
  - If (entry.strb & load_mask) == load_mask: fwd_hit=1, fwd_data=entry data. Otherwise fwd_stall=1 and fwd_data=0.
  - Older entries are not merged.
  - fwd_hit and fwd_stall are never both 1.
- Reset (asynchronous, any time including mid-WRITE):
  - head=tail=0, state=IDLE.
  - mem_wr_req=0, mem_wr_addr/data/strb=0; all entry contents are discarded.
  - Post-reset: enq_ready=1, empty=1, count=0.

Test Plan:
- SW 0x1000 data 0xDEADBEEF into empty buffer; ack on the 2nd req cycle -> mem_wr_req rises the cycle after the following edge. Writes addr 0x1000, data 0xDEADBEEF, strb 0xF. Count returns to 0 after ack.
- SB 0x1003 data 0x000000AB, then SH 0x2002 data 0x00001234 -> first write strb 0x8, data 0xABABABAB. Second write strb 0xC, data 0x12341234, addr 0x2000. Writes appear in order with one idle cycle between them.
- Fill 8 stores with mem_wr_ack held low -> enq_ready=0 and count=8. An enqueue attempt is dropped. After one ack, enq_ready=1 the next cycle and pointers wrap correctly.
- Buffered SW 0x3000=0x11223344, then SB 0x3001=0x55 -> LBU query at 0x3001 gives fwd_hit=1, fwd_data=0x55555555. LW query at 0x3000 gives fwd_stall=1. LB query at 0x3004 gives neither.
- Assert rst_n low during WRITE with 3 entries -> mem_wr_req drops immediately with no clock edge. After release: count=0, empty=1, no writes issued.
